// File: rtl/ifu_fetch_queue_pkg.sv
// ----------------------------------------------------------------------------
// ifu_fetch_queue_pkg
//   Shared constants and helpers for the instruction-fetch unit.
//   INSTR_W    : instruction word width
//   PC_STEP    : byte distance between sequential instructions
//   has_credit : true when one more fetch can be issued without the queue
//                overflowing once every in-flight response has landed
// ----------------------------------------------------------------------------
package ifu_fetch_queue_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned PC_STEP = 4;

  // Entries already queued plus the outstanding response, minus the entry
  // leaving this cycle, must stay below the queue depth.
  function automatic logic has_credit(input int unsigned count,
                                      input logic        inflight,
                                      input logic        pop,
                                      input int unsigned depth);
    return (count + {31'b0, inflight}) < (depth + {31'b0, pop});
  endfunction

endpackage

// File: rtl/ifu_fetch_queue_fifo.sv
// ----------------------------------------------------------------------------
// ifu_fetch_queue_fifo
//   Synchronous FIFO with a flush input and a combinational head read.
//   Ports:
//     clk, rst       clock, synchronous active-high reset (pointers/count only)
//     flush          discard every entry at the end of this cycle
//     wr_en, wr_data push an entry
//     rd_en          pop the head (ignored when empty)
//     rd_data        head entry, combinational
//     count          number of entries held
//     empty          count == 0
//   DEPTH must be a power of two, >= 2, so the pointers wrap naturally.
// ----------------------------------------------------------------------------
module ifu_fetch_queue_fifo #(
  parameter int WIDTH = 96,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             rd_ok;
  logic             wr_ok;

  assign empty   = (count == '0);
  assign rd_ok   = rd_en && !empty;
  assign wr_ok   = wr_en && !flush;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(wr_ok) - CW'(rd_ok);
    end
  end

  // Storage carries no reset; contents are only observed through count.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/ifu_fetch_queue.sv
// ----------------------------------------------------------------------------
// ifu_fetch_queue
//   Instruction-fetch unit with a decoupled fetch queue. Owns the fetch PC,
//   issues word requests to a 1-cycle synchronous IMEM, queues each returned
//   word with its PC and presents the queue head to decode via valid/ready.
//   A redirect reloads the fetch PC and flushes queued and in-flight fetches.
//   Ports:
//     sys_clk, sys_rst        clock, synchronous active-high reset
//     redirect_valid/_pc      load a new fetch PC (low two bits forced to 0)
//     imem_req, imem_addr     fetch request and its word address
//     imem_rdata              instruction word, valid the cycle after imem_req
//     id_valid, id_ready      head handshake to decode
//     id_pc, id_pc_plus_4     PC of head instruction and its successor
//     id_instr                head instruction word
// ----------------------------------------------------------------------------
module ifu_fetch_queue
  import ifu_fetch_queue_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = 64'h8000_0000,
  parameter int              IMEM_AW  = 8,
  parameter int              FQ_DEPTH = 4
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic               imem_req,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  output logic               id_valid,
  input  logic               id_ready,
  output logic [XLEN-1:0]    id_pc,
  output logic [XLEN-1:0]    id_pc_plus_4,
  output logic [31:0]        id_instr
);

  localparam int CNT_W   = $clog2(FQ_DEPTH) + 1;
  localparam int ENTRY_W = XLEN + INSTR_W;

  logic [XLEN-1:0]    fpc;
  logic [XLEN-1:0]    req_pc_p1;
  logic               vld_p1;
  logic               pop;
  logic               push;
  logic               fifo_empty;
  logic [CNT_W-1:0]   fifo_count;
  logic [ENTRY_W-1:0] head;
  logic [XLEN-1:0]    head_pc;
  logic [INSTR_W-1:0] head_instr;

  assign {head_pc, head_instr} = head;

  assign id_valid     = !sys_rst && !fifo_empty;
  // A redirect flushes the queue, so a same-cycle handshake is not a pop.
  assign pop          = id_valid && id_ready && !redirect_valid;
  assign push         = vld_p1 && !redirect_valid;

  assign imem_req     = !sys_rst && !redirect_valid &&
                        has_credit(32'(fifo_count), vld_p1, id_valid && id_ready, FQ_DEPTH);
  assign imem_addr    = fpc[IMEM_AW+1:2];

  assign id_pc        = id_valid ? head_pc : '0;
  assign id_pc_plus_4 = id_valid ? head_pc + XLEN'(PC_STEP) : '0;
  assign id_instr     = id_valid ? head_instr : '0;

  // ---- stage p0: fetch PC and request issue ----
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      fpc    <= RESET_PC;
      vld_p1 <= 1'b0;
    end else if (redirect_valid) begin
      fpc    <= redirect_pc & ~XLEN'(3);
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= imem_req;
      if (imem_req) fpc <= fpc + XLEN'(PC_STEP);
    end
  end

  // ---- stage p1: IMEM response returns, paired with its PC ----
  always_ff @(posedge sys_clk) begin
    if (imem_req) req_pc_p1 <= fpc;
  end

  ifu_fetch_queue_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FQ_DEPTH)
  ) u_fifo (
    .clk     (sys_clk),
    .rst     (sys_rst),
    .flush   (redirect_valid),
    .wr_en   (push),
    .wr_data ({req_pc_p1, imem_rdata}),
    .rd_en   (pop),
    .rd_data (head),
    .count   (fifo_count),
    .empty   (fifo_empty)
  );

endmodule

// File: tb/tb_ifu_fetch_queue.sv
// ----------------------------------------------------------------------------
// tb_ifu_fetch_queue
//   Self-checking bench for ifu_fetch_queue with a registered IMEM model.
// ----------------------------------------------------------------------------
module tb_ifu_fetch_queue;

  localparam int              XLEN     = 64;
  localparam logic [63:0]     RESET_PC = 64'h8000_0000;
  localparam int              IMEM_AW  = 8;
  localparam int              FQ_DEPTH = 4;

  logic               sys_clk = 1'b0;
  logic               sys_rst = 1'b1;
  logic               redirect_valid = 1'b0;
  logic [63:0]        redirect_pc = '0;
  logic               imem_req;
  logic [IMEM_AW-1:0] imem_addr;
  logic [31:0]        imem_rdata = '0;
  logic               id_valid;
  logic               id_ready = 1'b0;
  logic [63:0]        id_pc;
  logic [63:0]        id_pc_plus_4;
  logic [31:0]        id_instr;

  logic [31:0] mem_model [256];
  logic [63:0] mon_pc = RESET_PC;
  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        rst;
    logic        rv;
    logic [63:0] rpc;
    logic        rdy;
    logic        e_req;
    logic [7:0]  e_addr;
    logic        e_valid;
    logic        chk_pc;
    logic [63:0] e_pc;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];

  ifu_fetch_queue #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC),
    .IMEM_AW  (IMEM_AW),
    .FQ_DEPTH (FQ_DEPTH)
  ) dut (
    .sys_clk        (sys_clk),
    .sys_rst        (sys_rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_pc          (id_pc),
    .id_pc_plus_4   (id_pc_plus_4),
    .id_instr       (id_instr)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) imem_rdata <= mem_model[imem_addr];

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Independent stream model: every accepted head must be the next sequential
  // PC since the last reset/redirect, carrying the IMEM word at that PC.
  always @(negedge sys_clk) begin
    if (sys_rst) mon_pc = RESET_PC;
    else if (redirect_valid) mon_pc = redirect_pc & ~64'd3;
    else if (id_valid && id_ready) begin
      check64("mon_pc", id_pc, mon_pc);
      check64("mon_pc4", id_pc_plus_4, mon_pc + 64'd4);
      check64("mon_instr", 64'(id_instr), 64'(mem_model[mon_pc[9:2]]));
      mon_pc = mon_pc + 64'd4;
    end
  end

  task automatic cyc(input logic rst, input logic rv, input logic [63:0] rpc, input logic rdy);
    @(posedge sys_clk);
    #1;
    sys_rst        = rst;
    redirect_valid = rv;
    redirect_pc    = rpc;
    id_ready       = rdy;
    @(negedge sys_clk);
  endtask

  task automatic add(input logic rst, input logic rv, input logic [63:0] rpc, input logic rdy,
                     input logic e_req, input logic [7:0] e_addr, input logic e_valid,
                     input logic chk_pc, input logic [63:0] e_pc);
    vec_t v;
    v.rst = rst; v.rv = rv; v.rpc = rpc; v.rdy = rdy;
    v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
    v.chk_pc = chk_pc; v.e_pc = e_pc;
    vecs.push_back(v);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t e;
    int   nreq;
    for (int i = 0; i < 256; i++) mem_model[i] = $urandom;

    // rst rv rpc                    rdy req addr  vld chk pc
    add(1, 0, 64'h0,                 1,  0, 8'h00, 0, 1, 64'h0);
    add(1, 0, 64'h0,                 1,  0, 8'h00, 0, 1, 64'h0);
    add(0, 0, 64'h0,                 1,  1, 8'h00, 0, 0, 64'h0);
    add(0, 0, 64'h0,                 1,  1, 8'h01, 0, 0, 64'h0);
    add(0, 0, 64'h0,                 1,  1, 8'h02, 1, 1, 64'h8000_0000);
    add(0, 0, 64'h0,                 1,  1, 8'h03, 1, 1, 64'h8000_0004);
    add(0, 0, 64'h0,                 1,  1, 8'h04, 1, 1, 64'h8000_0008);
    add(0, 0, 64'h0,                 0,  1, 8'h05, 1, 1, 64'h8000_000C);
    add(0, 1, 64'h8000_0043,         0,  0, 8'h00, 1, 1, 64'h8000_000C);
    add(0, 0, 64'h0,                 1,  1, 8'h10, 0, 0, 64'h0);
    add(0, 0, 64'h0,                 1,  1, 8'h11, 0, 0, 64'h0);
    add(0, 0, 64'h0,                 1,  1, 8'h12, 1, 1, 64'h8000_0040);
    add(0, 0, 64'h0,                 1,  1, 8'h13, 1, 1, 64'h8000_0044);
    add(0, 1, 64'h8000_03FC,         1,  0, 8'h00, 1, 1, 64'h8000_0048);
    add(0, 0, 64'h0,                 1,  1, 8'hFF, 0, 0, 64'h0);
    add(0, 0, 64'h0,                 1,  1, 8'h00, 0, 0, 64'h0);
    add(0, 0, 64'h0,                 1,  1, 8'h01, 1, 1, 64'h8000_03FC);
    add(0, 0, 64'h0,                 1,  1, 8'h02, 1, 1, 64'h8000_0400);
    add(0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 1, 0, 8'h00, 1, 1, 64'h8000_0404);
    add(0, 0, 64'h0,                 1,  1, 8'hFF, 0, 0, 64'h0);
    add(0, 0, 64'h0,                 1,  1, 8'h00, 0, 0, 64'h0);
    add(0, 0, 64'h0,                 1,  1, 8'h01, 1, 1, 64'hFFFF_FFFF_FFFF_FFFC);
    add(0, 0, 64'h0,                 1,  1, 8'h02, 1, 1, 64'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      exp_q.push_back(vecs[i]);
      cyc(vecs[i].rst, vecs[i].rv, vecs[i].rpc, vecs[i].rdy);
      e = exp_q.pop_front();
      check64($sformatf("v%0d_req", i), 64'(imem_req), 64'(e.e_req));
      if (e.e_req) check64($sformatf("v%0d_addr", i), 64'(imem_addr), 64'(e.e_addr));
      check64($sformatf("v%0d_valid", i), 64'(id_valid), 64'(e.e_valid));
      if (e.chk_pc) begin
        check64($sformatf("v%0d_pc", i), id_pc, e.e_pc);
        check64($sformatf("v%0d_pc4", i), id_pc_plus_4, e.e_valid ? e.e_pc + 64'd4 : 64'd0);
        if (!e.e_valid) check64($sformatf("v%0d_instr", i), 64'(id_instr), 64'd0);
      end
    end

    // Back-pressure from reset: exactly FQ_DEPTH requests, then a gapless drain.
    cyc(1, 0, 64'h0, 0);
    cyc(1, 0, 64'h0, 0);
    nreq = 0;
    for (int k = 0; k < 8; k++) begin
      cyc(0, 0, 64'h0, 0);
      if (imem_req) nreq++;
    end
    check64("bp_nreq", 64'(nreq), 64'(FQ_DEPTH));
    check64("bp_head", id_pc, RESET_PC);
    for (int k = 0; k < 12; k++) begin
      cyc(0, 0, 64'h0, 1);
      check64($sformatf("drain%0d_valid", k), 64'(id_valid), 64'd1);
      check64($sformatf("drain%0d_pc", k), id_pc, RESET_PC + 64'(4 * k));
    end

    // Fill the queue, then redirect while decode accepts the head.
    for (int k = 0; k < 3; k++) cyc(0, 0, 64'h0, 0);
    check64("full_req", 64'(imem_req), 64'd0);
    check64("full_valid", 64'(id_valid), 64'd1);
    cyc(0, 1, 64'h8000_0100, 1);
    check64("rdpop_req", 64'(imem_req), 64'd0);
    cyc(0, 0, 64'h0, 1);
    check64("rdpop_t1_valid", 64'(id_valid), 64'd0);
    check64("rdpop_t1_addr", 64'(imem_addr), 64'h40);
    check64("rdpop_t1_req", 64'(imem_req), 64'd1);
    cyc(0, 0, 64'h0, 1);
    check64("rdpop_t2_valid", 64'(id_valid), 64'd0);
    check64("rdpop_t2_addr", 64'(imem_addr), 64'h41);
    cyc(0, 0, 64'h0, 1);
    check64("rdpop_t3_valid", 64'(id_valid), 64'd1);
    check64("rdpop_t3_pc", id_pc, 64'h8000_0100);
    cyc(0, 0, 64'h0, 1);
    check64("rdpop_t4_pc", id_pc, 64'h8000_0104);

    // Stall until the queue is full with one response still in flight, then reset.
    cyc(0, 0, 64'h0, 0);
    check64("prerst_req0", 64'(imem_req), 64'd1);
    check64("prerst_pc", id_pc, 64'h8000_0108);
    cyc(0, 0, 64'h0, 0);
    check64("prerst_req1", 64'(imem_req), 64'd1);
    cyc(1, 0, 64'h0, 0);
    check64("rst_valid", 64'(id_valid), 64'd0);
    check64("rst_req", 64'(imem_req), 64'd0);
    check64("rst_pc", id_pc, 64'd0);
    cyc(1, 0, 64'h0, 0);
    check64("rst2_valid", 64'(id_valid), 64'd0);
    check64("rst2_req", 64'(imem_req), 64'd0);
    cyc(0, 0, 64'h0, 1);
    check64("rel_req", 64'(imem_req), 64'd1);
    check64("rel_addr", 64'(imem_addr), 64'd0);
    check64("rel_valid", 64'(id_valid), 64'd0);
    cyc(0, 0, 64'h0, 1);
    check64("rel1_valid", 64'(id_valid), 64'd0);
    cyc(0, 0, 64'h0, 1);
    check64("rel2_valid", 64'(id_valid), 64'd1);
    check64("rel2_pc", id_pc, RESET_PC);
    for (int k = 0; k < 4; k++) cyc(0, 0, 64'h0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
